// File: rtl/field_renderer.sv
// Two-stage pixel renderer for a bat-and-ball playfield: lines, paddles, ball, optional score.
// Optional 7-segment score display is built when SCORE_DISP_EN is defined.
module field_renderer #(
    parameter int COLOR_W      = 4,
    parameter int NPAD         = 4,
    parameter int BALL_HALF    = 4,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   px_valid,
    input  logic [10:0]            x,
    input  logic [10:0]            y,
    input  logic [1:0]             mode,
    input  logic                   bat_size,
    input  logic [NPAD-1:0]        p_en,
    input  logic [NPAD*11-1:0]     p_x,
    input  logic [NPAD*11-1:0]     p_y,
    input  logic [10:0]            ball_x,
    input  logic [10:0]            ball_y,
    input  logic [5:0]             p1_score,
    input  logic [5:0]             p2_score,
    input  logic                   goal,
    output logic [3*COLOR_W-1:0]   px_color,
    output logic                   px_valid_out
);

    typedef enum logic [1:0] {
        MODE_TENNIS   = 2'b00,
        MODE_FOOTBALL = 2'b01,
        MODE_SQUASH   = 2'b10,
        MODE_PRACTICE = 2'b11
    } mode_e;

    localparam logic [COLOR_W-1:0]   C_ONES  = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0]   C_ZERO  = {COLOR_W{1'b0}};
    localparam logic [3*COLOR_W-1:0] C_WHITE = {3*COLOR_W{1'b1}};
    localparam logic [3*COLOR_W-1:0] C_RED   = {C_ONES, C_ZERO, C_ZERO};
    localparam logic [3*COLOR_W-1:0] C_GREEN = {C_ZERO, C_ONES, C_ZERO};
    localparam logic [3*COLOR_W-1:0] C_BLUE  = {C_ZERO, C_ZERO, C_ONES};

    function automatic logic in_rng(input logic [11:0] v, input logic [11:0] lo,
                                    input logic [11:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    // Frame-stable shadows; r_armed marks that at least one frame_start has been seen.
    mode_e                r_mode;
    logic                 r_bat;
    logic [NPAD-1:0]      r_p_en;
    logic [NPAD*11-1:0]   r_p_x;
    logic [NPAD*11-1:0]   r_p_y;
    logic                 r_armed;
    logic [7:0]           r_flash;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= MODE_TENNIS;
            r_bat   <= 1'b0;
            r_p_en  <= '0;
            r_p_x   <= '0;
            r_p_y   <= '0;
            r_armed <= 1'b0;
        end else if (frame_start) begin
            r_mode  <= mode_e'(mode);
            r_bat   <= bat_size;
            r_p_en  <= p_en;
            r_p_x   <= p_x;
            r_p_y   <= p_y;
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flash <= 8'd0;
        end else if (goal) begin
            r_flash <= 8'(BLINK_FRAMES);
        end else if (frame_start && (r_flash != 8'd0)) begin
            r_flash <= r_flash - 8'd1;
        end
    end

    logic [11:0] w_x12;
    logic [11:0] w_y12;
    logic [10:0] w_y_rel;
    logic        w_boundary;
    logic        w_middle;
    logic        w_goal_line;
    logic        w_wall;
    logic        w_flash_off;
    logic        w_lines;

    always_comb begin
        w_x12       = {1'b0, x};
        w_y12       = {1'b0, y};
        w_y_rel     = y - 11'd40;
        w_boundary  = in_rng(w_x12, 12'd20, 12'd620) &&
                      (in_rng(w_y12, 12'd20, 12'd30) || in_rng(w_y12, 12'd450, 12'd460));
        w_middle    = !r_mode[1] && in_rng(w_x12, 12'd325, 12'd335) &&
                      in_rng(w_y12, 12'd40, 12'd440) && ((w_y_rel % 11'd20) < 11'd10);
        w_goal_line = (in_rng(w_y12, 12'd20, 12'd130) || in_rng(w_y12, 12'd350, 12'd460)) &&
                      ((in_rng(w_x12, 12'd20, 12'd30) && (r_mode != MODE_TENNIS)) ||
                       (in_rng(w_x12, 12'd610, 12'd620) && (r_mode == MODE_FOOTBALL)));
        w_wall      = r_mode[1] && in_rng(w_x12, 12'd20, 12'd30) &&
                      in_rng(w_y12, 12'd130, 12'd350);
        w_flash_off = (r_flash != 8'd0) && r_flash[2];
        w_lines     = !w_flash_off && (w_boundary || w_middle || w_goal_line || w_wall);
    end

    logic [11:0] w_bx_lo;
    logic [11:0] w_by_lo;
    logic        w_ball;

    always_comb begin
        w_bx_lo = (ball_x >= 11'(BALL_HALF)) ? ({1'b0, ball_x} - 12'(BALL_HALF)) : 12'd0;
        w_by_lo = (ball_y >= 11'(BALL_HALF)) ? ({1'b0, ball_y} - 12'(BALL_HALF)) : 12'd0;
        w_ball  = in_rng(w_x12, w_bx_lo, {1'b0, ball_x} + 12'(BALL_HALF)) &&
                  in_rng(w_y12, w_by_lo, {1'b0, ball_y} + 12'(BALL_HALF));
    end

    logic [NPAD-1:0] w_pad_hit;
    logic [11:0]     w_half;
    logic [11:0]     w_px;
    logic [11:0]     w_py;
    logic [11:0]     w_py_lo;

    // NOTE: every always_comb output is given a default before any branch or loop, so no latch is inferred.
    always_comb begin
        w_pad_hit = '0;
        w_px      = 12'd0;
        w_py      = 12'd0;
        w_py_lo   = 12'd0;
        w_half    = r_bat ? 12'd35 : 12'd25;
        for (int i = 0; i < NPAD; i++) begin
            w_px         = {1'b0, r_p_x[11*i +: 11]};
            w_py         = {1'b0, r_p_y[11*i +: 11]};
            w_py_lo      = (w_py < w_half) ? 12'd0 : (w_py - w_half);
            w_pad_hit[i] = r_armed && r_p_en[i] &&
                           in_rng(w_x12, w_px, w_px + 12'd10) &&
                           in_rng(w_y12, w_py_lo, w_py + w_half);
        end
    end

    logic w_score;

`ifdef SCORE_DISP_EN
    logic [5:0] r_p1_score;
    logic [5:0] r_p2_score;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_score <= 6'd0;
            r_p2_score <= 6'd0;
        end else if (frame_start) begin
            r_p1_score <= p1_score;
            r_p2_score <= p2_score;
        end
    end

    // Segment bits ordered {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // 20x30 glyph at (gx,35), segments 4 pixels thick.
    function automatic logic glyph_hit(input logic [3:0] digit, input logic [11:0] gx,
                                       input logic [11:0] px, input logic [11:0] py);
        logic [6:0]  s;
        logic [11:0] rx;
        logic [11:0] ry;
        s  = seg7(digit);
        rx = px - gx;
        ry = py - 12'd35;
        if (!in_rng(px, gx, gx + 12'd20) || !in_rng(py, 12'd35, 12'd65)) return 1'b0;
        return (s[6] && (ry < 12'd4)) ||
               (s[5] && (rx >= 12'd16) && (ry < 12'd15)) ||
               (s[4] && (rx >= 12'd16) && (ry >= 12'd15)) ||
               (s[3] && (ry >= 12'd26)) ||
               (s[2] && (rx < 12'd4) && (ry >= 12'd15)) ||
               (s[1] && (rx < 12'd4) && (ry < 12'd15)) ||
               (s[0] && in_rng(ry, 12'd13, 12'd17));
    endfunction

    always_comb begin
        w_score = r_armed && (
            glyph_hit(4'(r_p1_score / 6'd10), 12'd260, w_x12, w_y12) ||
            glyph_hit(4'(r_p1_score % 6'd10), 12'd285, w_x12, w_y12) ||
            glyph_hit(4'(r_p2_score / 6'd10), 12'd350, w_x12, w_y12) ||
            glyph_hit(4'(r_p2_score % 6'd10), 12'd375, w_x12, w_y12));
    end
`else
    logic w_unused_scores;
    assign w_unused_scores = ^{p1_score, p2_score};
    assign w_score         = 1'b0;
`endif

    logic            r_s1_valid;
    logic            r_s1_ball;
    logic [NPAD-1:0] r_s1_pad;
    logic            r_s1_score;
    logic            r_s1_lines;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_ball  <= 1'b0;
            r_s1_pad   <= '0;
            r_s1_score <= 1'b0;
            r_s1_lines <= 1'b0;
        end else begin
            r_s1_valid <= px_valid;
            r_s1_ball  <= w_ball;
            r_s1_pad   <= w_pad_hit;
            r_s1_score <= w_score;
            r_s1_lines <= w_lines;
        end
    end

    logic [3*COLOR_W-1:0] w_pad_color;
    logic [3*COLOR_W-1:0] w_color;

    always_comb begin
        w_pad_color = '0;
        // Walk from the highest slot down so the lowest enabled index overrides.
        for (int i = NPAD - 1; i >= 0; i--) begin
            if (r_s1_pad[i]) w_pad_color = (i % 2 == 0) ? C_RED : C_BLUE;
        end
        w_color = '0;
        if (r_s1_valid) begin
            if (r_s1_ball)        w_color = C_WHITE;
            else if (|r_s1_pad)   w_color = w_pad_color;
            else if (r_s1_score)  w_color = C_GREEN;
            else if (r_s1_lines)  w_color = C_WHITE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_color     <= '0;
            px_valid_out <= 1'b0;
        end else begin
            px_color     <= w_color;
            px_valid_out <= r_s1_valid;
        end
    end

endmodule

// File: tb/tb_field_renderer.sv
// Directed self-checking bench for field_renderer: reset, shadows, paddles, ball, modes, flash, score.
module tb_field_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        px_valid;
    logic [10:0] x;
    logic [10:0] y;
    logic [1:0]  mode;
    logic        bat_size;
    logic [3:0]  p_en;
    logic [43:0] p_x;
    logic [43:0] p_y;
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic [5:0]  p1_score;
    logic [5:0]  p2_score;
    logic        goal;
    logic [11:0] px_color;
    logic        px_valid_out;

    int n_checks = 0;
    int n_pass   = 0;

    field_renderer dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .px_valid     (px_valid),
        .x            (x),
        .y            (y),
        .mode         (mode),
        .bat_size     (bat_size),
        .p_en         (p_en),
        .p_x          (p_x),
        .p_y          (p_y),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .goal         (goal),
        .px_color     (px_color),
        .px_valid_out (px_valid_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present one pixel, then sample the colour two clock edges later on a falling edge.
    task automatic probe(input string tag, input int px, input int py, input logic [11:0] exp);
        @(negedge clk);
        x        = 11'(px);
        y        = 11'(py);
        px_valid = 1'b1;
        @(negedge clk);
        px_valid = 1'b0;
        @(negedge clk);
        check(tag, {20'd0, px_color}, {20'd0, exp});
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
    endtask

    task automatic pulse_goal();
        @(negedge clk);
        goal = 1'b1;
        @(negedge clk);
        goal = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        px_valid    = 1'b0;
        x           = 11'd0;
        y           = 11'd0;
        mode        = 2'b00;
        bat_size    = 1'b0;
        p_en        = 4'b0000;
        p_x         = '0;
        p_y         = '0;
        ball_x      = 11'd1000;
        ball_y      = 11'd1000;
        p1_score    = 6'd0;
        p2_score    = 6'd0;
        goal        = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_color", {20'd0, px_color}, 32'h0);
        check("reset_valid", {31'd0, px_valid_out}, 32'h0);
        rst = 1'b0;

        // Non-default shadows, then a mid-frame reset with a white pixel streaming.
        mode          = 2'b10;
        p_en          = 4'b0001;
        p_x[10:0]     = 11'd40;
        p_y[10:0]     = 11'd200;
        frames(1);
        @(negedge clk);
        x        = 11'd100;
        y        = 11'd25;
        px_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_white", {20'd0, px_color}, 32'hFFF);
        #2 rst = 1'b1;
        #1 check("midframe_rst_color", {20'd0, px_color}, 32'h0);
        check("midframe_rst_valid", {31'd0, px_valid_out}, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_held_color", {20'd0, px_color}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_boundary", {20'd0, px_color}, 32'hFFF);
        check("post_rst_valid", {31'd0, px_valid_out}, 32'h1);
        px_valid = 1'b0;

        // Before the first frame_start: mode-00 lines only, enabled paddle not drawn.
        probe("nofs_middle_dash", 330, 45, 12'hFFF);
        probe("nofs_middle_gap", 330, 55, 12'h000);
        probe("nofs_paddle_hidden", 45, 200, 12'h000);
        probe("nofs_no_wall", 25, 200, 12'h000);

        // Shadow latching of paddle position.
        mode = 2'b00;
        frames(1);
        probe("shadow_paddle_on", 45, 200, 12'hF00);
        p_y[10:0] = 11'd300;
        probe("shadow_hold_midframe", 45, 200, 12'hF00);
        frames(1);
        probe("shadow_after_fs", 45, 200, 12'h000);
        probe("paddle_new_pos", 45, 290, 12'hF00);

        // Paddle priority, colours and edges.
        p_en        = 4'b0011;
        p_x[21:11]  = 11'd40;
        p_y[21:11]  = 11'd290;
        frames(1);
        probe("overlap_lowest_wins", 45, 300, 12'hF00);
        probe("odd_slot_blue", 45, 268, 12'h00F);
        probe("paddle_x_lo_edge", 40, 300, 12'hF00);
        probe("paddle_x_hi_excl", 50, 300, 12'h000);
        probe("paddle_y_hi_excl", 45, 325, 12'h000);

        // Clamped paddle and ball priority.
        p_en      = 4'b0001;
        p_y[10:0] = 11'd10;
        bat_size  = 1'b1;
        frames(1);
        probe("clamp_paddle_y0", 45, 0, 12'hF00);
        probe("bat35_last_row", 45, 44, 12'hF00);
        probe("bat35_excl", 45, 45, 12'h000);
        ball_x = 11'd45;
        ball_y = 11'd5;
        probe("ball_over_paddle", 45, 5, 12'hFFF);
        ball_y = 11'd2;
        probe("ball_clamp_y0", 45, 0, 12'hFFF);
        ball_x = 11'd200;
        ball_y = 11'd200;
        probe("ball_lo_corner", 196, 196, 12'hFFF);
        probe("ball_x_hi_excl", 204, 200, 12'h000);
        probe("ball_hi_corner", 203, 203, 12'hFFF);
        ball_x = 11'd1000;
        ball_y = 11'd1000;

        // Mode-dependent lines.
        mode = 2'b10;
        frames(1);
        probe("squash_no_middle", 330, 45, 12'h000);
        probe("squash_wall", 25, 200, 12'hFFF);
        probe("squash_no_right_goal", 615, 100, 12'h000);
        mode = 2'b01;
        frames(1);
        probe("football_right_goal", 615, 100, 12'hFFF);
        probe("football_left_goal", 25, 100, 12'hFFF);
        probe("football_no_wall", 25, 200, 12'h000);
        probe("football_middle", 330, 45, 12'hFFF);
        mode = 2'b11;
        frames(1);
        probe("practice_wall", 25, 200, 12'hFFF);
        probe("practice_no_middle", 330, 45, 12'h000);

        // Goal flash timing.
        mode = 2'b00;
        frames(1);
        pulse_goal();
        probe("flash_cnt32", 100, 25, 12'hFFF);
        frames(4);
        probe("flash_cnt28_off", 100, 25, 12'h000);
        probe("flash_paddle_kept", 45, 0, 12'hF00);
        frames(4);
        probe("flash_cnt24_on", 100, 25, 12'hFFF);
        frames(4);
        probe("flash_cnt20_off", 100, 25, 12'h000);
        frames(20);
        probe("flash_cnt0_on", 100, 25, 12'hFFF);
        frames(3);
        probe("flash_stays_off", 100, 25, 12'hFFF);

        // Goal coincident with frame_start: counter loads 32 and mode still latches.
        mode = 2'b10;
        @(negedge clk);
        goal        = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        goal        = 1'b0;
        frame_start = 1'b0;
        probe("coinc_latched_wall", 25, 200, 12'hFFF);
        frames(4);
        probe("coinc_cnt28_off", 25, 200, 12'h000);
        pulse_goal();
        probe("reload_cnt32_on", 25, 200, 12'hFFF);
        frames(4);
        probe("reload_cnt28_off", 25, 200, 12'h000);

        // Score glyphs.
        p1_score = 6'd47;
        frames(1);
`ifdef SCORE_DISP_EN
        probe("score47_units_a", 295, 36, 12'h0F0);
        probe("score47_tens_g", 270, 50, 12'h0F0);
        probe("score47_units_g_off", 295, 50, 12'h000);
        p1_score = 6'd0;
        frames(1);
        probe("score0_tens_g_off", 270, 50, 12'h000);
        probe("score0_tens_a", 270, 36, 12'h0F0);
`else
        probe("noscore_tens", 270, 50, 12'h000);
        probe("noscore_units", 295, 36, 12'h000);
`endif

        // Invalid pixel on a paddle gives black.
        @(negedge clk);
        x        = 11'd45;
        y        = 11'd0;
        px_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("invalid_black", {20'd0, px_color}, 32'h0);
        check("invalid_valid_out", {31'd0, px_valid_out}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
